// File: rtl/wdog_ctrl_if.sv
// Bundles the watchdog's configuration write port, timer count and status outputs.
// master = register decode / timer side, slave = wdog_ctrl.
interface wdog_ctrl_if #(
  parameter int WDOG_CNT = 16
);
  logic                cfg_we;
  logic [1:0]          cfg_addr;
  logic [15:0]         cfg_wdata;
  logic [WDOG_CNT-1:0] wdog_timer_cnt;
  logic                wdog_act;
  logic                wdog_relaod;
  logic                wdog_irq;
  logic                wdog_rst_req;
  logic [1:0]          wdog_state;
  logic                wdog_locked;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, wdog_timer_cnt,
    input  wdog_act, wdog_relaod, wdog_irq, wdog_rst_req, wdog_state, wdog_locked
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, wdog_timer_cnt,
    output wdog_act, wdog_relaod, wdog_irq, wdog_rst_req, wdog_state, wdog_locked
  );
endinterface

// File: rtl/wdog_ctrl.sv
// Watchdog sequencer: IDLE -> RUN -> WARN (irq) -> RESET (rst_req), with keyed feed and register lock.
// All outputs registered; WDOG_CNT must not exceed the 16-bit write data width.
module wdog_ctrl #(
  parameter int          WDOG_CNT   = 16,
  parameter int          RST_CYCLES = 8,
  parameter logic [15:0] FEED_KEY0  = 16'hA5A5,
  parameter logic [15:0] FEED_KEY1  = 16'h5A5A,
  parameter logic [15:0] UNLOCK_KEY = 16'h1ACC
) (
  input logic        fclk,
  input logic        sys_rst_n,
  wdog_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WARN  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  localparam logic [WDOG_CNT-1:0] LOAD_ONE = {{(WDOG_CNT-1){1'b0}}, 1'b1};
  localparam logic [7:0]          RST_LAST = 8'(RST_CYCLES - 1);

  state_t              state_q, state_d;
  logic                act_q, act_d;
  logic                relaod_q, relaod_d;
  logic                irq_q, irq_d;
  logic                rst_req_q, rst_req_d;
  logic                locked_q, locked_d;
  logic                en_q, en_d;
  logic                rst_en_q, rst_en_d;
  logic [WDOG_CNT-1:0] load_q, load_d;
  logic                key_armed_q, key_armed_d;
  logic [7:0]          rst_cnt_q, rst_cnt_d;
  logic                mask_q, mask_d;

  logic                ctrl_wr, load_wr, key_wr, lock_wr;
  logic                feed, timeout;
  logic [WDOG_CNT-1:0] wdata_load;

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    relaod_d    = 1'b0;
    irq_d       = irq_q;
    rst_req_d   = rst_req_q;
    locked_d    = locked_q;
    en_d        = en_q;
    rst_en_d    = rst_en_q;
    load_d      = load_q;
    key_armed_d = key_armed_q;
    rst_cnt_d   = rst_cnt_q;
    mask_d      = relaod_q;
    feed        = 1'b0;

    ctrl_wr    = bus.cfg_we && (bus.cfg_addr == 2'd0) && !locked_q && (state_q != ST_RESET);
    load_wr    = bus.cfg_we && (bus.cfg_addr == 2'd1) && !locked_q && (state_q != ST_RESET);
    key_wr     = bus.cfg_we && (bus.cfg_addr == 2'd2);
    lock_wr    = bus.cfg_we && (bus.cfg_addr == 2'd3);
    wdata_load = bus.cfg_wdata[WDOG_CNT-1:0];

    // The count seen during and just after a reload is stale, so it cannot time out.
    timeout = (bus.wdog_timer_cnt >= load_q) && !relaod_q && !mask_q;

    if (lock_wr) locked_d = (bus.cfg_wdata != UNLOCK_KEY);

    if (key_wr) begin
      if (bus.cfg_wdata == FEED_KEY0) begin
        key_armed_d = 1'b1;
      end else begin
        key_armed_d = 1'b0;
        feed        = (bus.cfg_wdata == FEED_KEY1) && key_armed_q;
      end
    end

    if (ctrl_wr) begin
      en_d     = bus.cfg_wdata[0];
      rst_en_d = bus.cfg_wdata[1];
    end

    if (load_wr) load_d = (wdata_load == '0) ? LOAD_ONE : wdata_load;

    case (state_q)
      ST_IDLE: begin
        act_d     = 1'b0;
        irq_d     = 1'b0;
        rst_req_d = 1'b0;
        if (ctrl_wr && bus.cfg_wdata[0]) begin
          state_d  = ST_RUN;
          act_d    = 1'b1;
          relaod_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ctrl_wr && !bus.cfg_wdata[0]) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
          irq_d   = 1'b0;
        end else if (feed) begin
          relaod_d = 1'b1;
        end else if (timeout) begin
          state_d  = ST_WARN;
          relaod_d = 1'b1;
          irq_d    = 1'b1;
        end
      end
      ST_WARN: begin
        if (ctrl_wr && !bus.cfg_wdata[0]) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
          irq_d   = 1'b0;
        end else if (feed) begin
          state_d  = ST_RUN;
          relaod_d = 1'b1;
          irq_d    = 1'b0;
        end else if (timeout) begin
          if (rst_en_q) begin
            state_d   = ST_RESET;
            act_d     = 1'b0;
            rst_req_d = 1'b1;
            rst_cnt_d = RST_LAST;
          end else begin
            relaod_d = 1'b1;
          end
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == 8'd0) begin
          state_d   = ST_IDLE;
          irq_d     = 1'b0;
          rst_req_d = 1'b0;
          en_d      = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      act_q       <= 1'b0;
      relaod_q    <= 1'b0;
      irq_q       <= 1'b0;
      rst_req_q   <= 1'b0;
      locked_q    <= 1'b0;
      en_q        <= 1'b0;
      rst_en_q    <= 1'b0;
      load_q      <= '1;
      key_armed_q <= 1'b0;
      rst_cnt_q   <= 8'd0;
      mask_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      relaod_q    <= relaod_d;
      irq_q       <= irq_d;
      rst_req_q   <= rst_req_d;
      locked_q    <= locked_d;
      en_q        <= en_d;
      rst_en_q    <= rst_en_d;
      load_q      <= load_d;
      key_armed_q <= key_armed_d;
      rst_cnt_q   <= rst_cnt_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.wdog_act     = act_q;
  assign bus.wdog_relaod  = relaod_q;
  assign bus.wdog_irq     = irq_q;
  assign bus.wdog_rst_req = rst_req_q;
  assign bus.wdog_state   = state_q;
  assign bus.wdog_locked  = locked_q;

endmodule

// File: tb/tb_wdog_ctrl.sv
// Directed bench for wdog_ctrl with a behavioural watchdog timer closing the loop.
// Edge numbers in comments count posedges from the CTRL write that first starts the watchdog.
module tb_wdog_ctrl;

  logic        fclk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] timer_cnt = '0;
  int          compared = 0;
  int          mismatched = 0;

  wdog_ctrl_if #(.WDOG_CNT(16)) bus ();

  wdog_ctrl dut (
    .fclk      (fclk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 fclk = ~fclk;

  // Timer model: reload wins, otherwise saturating count while active.
  always @(posedge fclk) begin
    if (bus.wdog_relaod)                       timer_cnt <= '0;
    else if (bus.wdog_act && timer_cnt != '1) timer_cnt <= timer_cnt + 16'd1;
  end
  assign bus.wdog_timer_cnt = timer_cnt;

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutputs(input string tag, input logic [1:0] st, input logic act,
                              input logic rl, input logic irq, input logic rr);
    checkOutput({tag, ".state"},   16'(bus.wdog_state),   16'(st));
    checkOutput({tag, ".act"},     16'(bus.wdog_act),     16'(act));
    checkOutput({tag, ".relaod"},  16'(bus.wdog_relaod),  16'(rl));
    checkOutput({tag, ".irq"},     16'(bus.wdog_irq),     16'(irq));
    checkOutput({tag, ".rst_req"}, 16'(bus.wdog_rst_req), 16'(rr));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    sys_rst_n     = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 16'd0;
    tick(2);
    checkOutputs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.locked", 16'(bus.wdog_locked), 16'd0);
    sys_rst_n = 1'b1;
    tick(1);

    // LOAD=10, rst_en=0: first timeout twelve edges after the start reload
    applyStimulus(2'd1, 16'd10);
    applyStimulus(2'd0, 16'h0001);                                  // E1
    checkOutputs("start", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);                                                        // E2
    checkOutput("start.pulse_one_cycle", 16'(bus.wdog_relaod), 16'd0);
    tick(10);                                                       // E12: cnt=10 now
    checkOutputs("pre_timeout", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);                                                        // E13
    checkOutputs("timeout_warn", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(11);                                                       // E24
    checkOutputs("warn_wait", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);                                                        // E25
    checkOutputs("warn_rearm", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

    // Feed from WARN returns to RUN
    applyStimulus(2'd2, 16'hA5A5);                                  // E26
    applyStimulus(2'd2, 16'h5A5A);                                  // E27
    checkOutputs("warn_feed", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Feed in RUN mid-count
    tick(6);                                                        // E33
    applyStimulus(2'd2, 16'hA5A5);                                  // E34
    checkOutput("armed.no_pulse", 16'(bus.wdog_relaod), 16'd0);
    applyStimulus(2'd2, 16'h5A5A);                                  // E35
    checkOutputs("run_feed", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Broken key sequence: no feed, timeout at E47
    applyStimulus(2'd2, 16'hA5A5);                                  // E36
    applyStimulus(2'd2, 16'h1234);                                  // E37
    applyStimulus(2'd2, 16'h5A5A);                                  // E38
    checkOutputs("bad_seq", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(8);                                                        // E46
    checkOutput("bad_seq.pre", 16'(bus.wdog_irq), 16'd0);
    tick(1);                                                        // E47
    checkOutputs("bad_seq.timeout", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

    applyStimulus(2'd0, 16'h0000);                                  // E48
    checkOutputs("disable_warn", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LOAD=4, rst_en=1: WARN at E56, RESET at E62 for 8 cycles
    applyStimulus(2'd1, 16'd4);                                     // E49
    applyStimulus(2'd0, 16'h0003);                                  // E50
    checkOutputs("rst_start", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(5);                                                        // E55
    checkOutput("rst.pre_warn", 16'(bus.wdog_state), 16'd1);
    tick(1);                                                        // E56
    checkOutputs("rst.warn", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(5);                                                        // E61
    checkOutputs("rst.pre_reset", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);                                                        // E62
    checkOutputs("rst.enter", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(7);                                                        // E69
    checkOutputs("rst.last", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);                                                        // E70
    checkOutputs("rst.exit", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lock blocks CTRL and LOAD writes; timeout stays on LOAD=4 schedule
    applyStimulus(2'd0, 16'h0001);                                  // E71
    applyStimulus(2'd3, 16'h0000);                                  // E72
    checkOutput("lock.set", 16'(bus.wdog_locked), 16'd1);
    applyStimulus(2'd0, 16'h0000);                                  // E73
    checkOutputs("lock.ctrl_ignored", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd1, 16'd100);                                   // E74
    tick(2);                                                        // E76
    checkOutput("lock.pre_timeout", 16'(bus.wdog_state), 16'd1);
    tick(1);                                                        // E77
    checkOutputs("lock.load_ignored", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'd3, 16'h1ACC);                                  // E78
    checkOutput("lock.clear", 16'(bus.wdog_locked), 16'd0);
    applyStimulus(2'd0, 16'h0000);                                  // E79
    checkOutputs("unlock.disable", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Feed completes on the very edge the timeout would fire (E86)
    applyStimulus(2'd0, 16'h0001);                                  // E80
    tick(4);                                                        // E84
    applyStimulus(2'd2, 16'hA5A5);                                  // E85
    checkOutputs("race.armed", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd2, 16'h5A5A);                                  // E86
    checkOutputs("race.feed_wins", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reach RESET, then pull sys_rst_n mid-request
    applyStimulus(2'd0, 16'h0003);                                  // E87
    checkOutputs("race.ctrl3_in_run", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd3, 16'h0005);                                  // E88
    tick(3);                                                        // E91
    checkOutput("abort.pre_warn", 16'(bus.wdog_state), 16'd1);
    tick(1);                                                        // E92
    checkOutput("abort.warn", 16'(bus.wdog_state), 16'd2);
    tick(6);                                                        // E98
    checkOutputs("abort.reset", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(3);                                                        // E101
    checkOutput("abort.mid_reset", 16'(bus.wdog_rst_req), 16'd1);
    sys_rst_n = 1'b0;
    tick(1);                                                        // E102
    checkOutputs("abort.reset_values", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort.locked", 16'(bus.wdog_locked), 16'd0);
    sys_rst_n = 1'b1;
    tick(2);
    checkOutputs("abort.after", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wdog_ctrl.md
Name: wdog_ctrl

Overview:
Watchdog sequencer that drives the watchdog timer's activation and reload inputs, and compares the timer's count against a programmable timeout. It escalates through a warning interrupt and then a system-reset request. A small configuration write port provides enable, timeout, a two-key feed sequence and a register lock. The block sits between the SoC register bus decode and the watchdog timer, and its reset request goes to the reset controller.

Parameters:
WDOG_CNT, 16, timer counter width; also the LOAD register width
RST_CYCLES, 8, number of cycles wdog_rst_req is held high (range 1..255)
FEED_KEY0, 16'hA5A5, first feed key
FEED_KEY1, 16'h5A5A, second feed key
UNLOCK_KEY, 16'h1ACC, value that clears the lock

Ports:
fclk  in  1  clock; only clock in the block
sys_rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of fclk
cfg_we  in  1  configuration write strobe, one cycle per write
cfg_addr  in  2  0=CTRL, 1=LOAD, 2=KEY, 3=LOCK
cfg_wdata  in  16  write data
wdog_timer_cnt  in  WDOG_CNT  current count from the timer
wdog_act  out  1  timer count enable
wdog_relaod  out  1  timer reload strobe, one cycle
wdog_irq  out  1  warning interrupt, level
wdog_rst_req  out  1  system reset request
wdog_state  out  2  0=IDLE, 1=RUN, 2=WARN, 3=RESET
wdog_locked  out  1  CTRL/LOAD write lock status

Behaviour:
- Timer contract:
  - Reload → count 0 on the next edge.
  - Else act=1 → increment, saturating at all-ones.
  - Else hold.
- All outputs are registered. A cfg write in cycle n is visible on outputs in cycle n+1.
- Reset values:
  - Outputs: state=IDLE, act=0, relaod=0, irq=0, rst_req=0, locked=0.
  - Registers: CTRL.en=0, CTRL.rst_en=0, LOAD=all-ones, key_armed=0.
- CTRL register: bit0=en, bit1=rst_en. Writes are ignored while locked.
- LOAD register: timeout value, low WDOG_CNT bits of cfg_wdata. A write of 0 stores 1. Writes are ignored while locked.
- LOCK register:
  - Writing UNLOCK_KEY clears locked.
  - Writing any other value sets locked.
  - Always writable.
- KEY register (always writable):
  - Writing FEED_KEY0 sets key_armed.
  - Writing FEED_KEY1 while key_armed produces a feed and clears key_armed.
  - Any other KEY write clears key_armed.
  - Writes to other addresses do not affect key_armed.
- Timeout condition: wdog_timer_cnt >= LOAD. It is masked while wdog_relaod=1 and for the one cycle after, so a stale count cannot re-trigger.
- IDLE:
  - act=0, irq=0.
  - CTRL.en rising (write en=1) → relaod pulse, then RUN.
  - Feeds are ignored.
- RUN:
  - act=1.
  - Feed → relaod pulse, stay in RUN.
  - Timeout → relaod pulse, irq=1, go to WARN.
- WARN:
  - act=1, irq=1.
  - Feed → relaod pulse, irq=0, go to RUN.
  - Timeout with rst_en=1 → RESET.
  - Timeout with rst_en=0 → relaod pulse, stay in WARN with irq held.
- RESET:
  - act=0, irq=1, rst_req=1 for exactly RST_CYCLES cycles.
  - Then go to IDLE with irq=0, rst_req=0, CTRL.en cleared.
  - Feeds, CTRL writes and LOAD writes are ignored in RESET; LOCK and KEY writes are still accepted.
- Writing en=0 in RUN or WARN → IDLE, irq=0, act=0, no reload.
- Simultaneous feed and timeout in the same cycle → the feed wins.
- A LOAD write in RUN takes effect on the next comparison; it does not trigger a reload.
- sys_rst_n low in any state → reset values on the next edge. A rst_req in progress is aborted.

Test Plan:
- Reset, write LOAD=10, CTRL=1 → relaod pulses 1 cycle later, act=1. With no feed, irq rises once cnt reaches 10 and state=WARN.
- In RUN at cnt=5, write KEY=A5A5 then KEY=5A5A → relaod pulse the cycle after the second write, state stays RUN, irq stays 0.
- KEY=A5A5, KEY=1234, KEY=5A5A → no feed, and timeout occurs on schedule.
- CTRL=3, LOAD=4, no feeds → WARN, then RESET with rst_req high exactly 8 cycles, then IDLE with CTRL.en=0. Repeat with CTRL=1 → stays in WARN, relaod pulses every timeout, rst_req never asserts.
- LOCK=0 → locked=1, then CTRL=0 is ignored and the watchdog keeps running. LOCK=1ACC → locked=0, then CTRL=0 → IDLE, act=0.
- Feed lands in the same cycle as the timeout, and sys_rst_n is asserted low mid-RESET → RUN is kept with no irq; all outputs reach reset values one edge later.
